// File: rtl/vga_game_pkg.sv
// Shared playfield constants, motion state encodings and colour palette
// for the VGA game blocks.
package vga_game_pkg;

    typedef enum logic [1:0] {
        ST_GROUND  = 2'd0,
        ST_RISING  = 2'd1,
        ST_FALLING = 2'd2
    } motion_state_e;

    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int GROUND_Y = 384;
    localparam int DIRT_TOP = 400;

    // 6-bit RrGgBb colours
    localparam logic [5:0] COL_BLACK  = 6'b00_00_00;
    localparam logic [5:0] COL_SKY    = 6'b01_10_11;
    localparam logic [5:0] COL_GRASS  = 6'b00_10_00;
    localparam logic [5:0] COL_DIRT   = 6'b10_01_00;
    localparam logic [5:0] COL_PLAYER = 6'b11_11_00;
    localparam logic [5:0] COL_SPRITE = 6'b11_00_11;
    localparam logic [5:0] COL_WHITE  = 6'b11_11_11;

endpackage

// File: rtl/sprite_motion_if.sv
// Frame/beam inputs and sprite position outputs of one sprite motion engine.
// Inputs are sampled on every clk edge; there is no back-pressure.
interface sprite_motion_if #(
    parameter int COORD_W = 10
);
    logic               i_frame_end;
    logic               i_jump;
    logic               i_pause;
    logic [COORD_W-1:0] i_h;
    logic [COORD_W-1:0] i_v;
    logic [COORD_W-1:0] o_px;
    logic [COORD_W-1:0] o_py;
    logic               o_dx;
    logic [1:0]         o_state;
    logic               o_in_sprite;

    modport master (
        output i_frame_end, i_jump, i_pause, i_h, i_v,
        input  o_px, o_py, o_dx, o_state, o_in_sprite
    );

    modport slave (
        input  i_frame_end, i_jump, i_pause, i_h, i_v,
        output o_px, o_py, o_dx, o_state, o_in_sprite
    );
endinterface

// File: rtl/sprite_hit.sv
// Combinational rectangle hit test: is the beam inside a SPR_W x SPR_H box
// whose left edge is i_x and whose exclusive bottom edge is i_y_bot.
module sprite_hit #(
    parameter int COORD_W = 10,
    parameter int SPR_W   = 16,
    parameter int SPR_H   = 16
) (
    input  logic [COORD_W-1:0] i_h,
    input  logic [COORD_W-1:0] i_v,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W:0]   i_y_bot,
    output logic               o_hit
);
    typedef logic [COORD_W:0] wide_t;

    wide_t h_w, v_w, x_w;

    assign h_w = {1'b0, i_h};
    assign v_w = {1'b0, i_v};
    assign x_w = {1'b0, i_x};

    // v >= bot - H is rewritten as v + H >= bot so nothing can underflow
    assign o_hit = (h_w >= x_w)
                && (h_w < x_w + wide_t'(SPR_W))
                && (v_w + wide_t'(SPR_H) >= i_y_bot)
                && (v_w < i_y_bot);

endmodule

// File: rtl/sprite_motion.sv
// Per-frame motion engine for one sprite: horizontal bounce between the
// playfield edges plus a gravity jump, updated once per unpaused frame end.
module sprite_motion #(
    parameter int COORD_W     = 10,
    parameter int H_RES       = vga_game_pkg::H_RES,
    parameter int GROUND_Y    = vga_game_pkg::GROUND_Y,
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int X_SPEED     = 1,
    parameter int JUMP_V      = 12,
    parameter int GRAVITY_DIV = 1
) (
    input  logic           clk,
    input  logic           reset,
    sprite_motion_if.slave bus
);
    typedef logic [COORD_W:0]   wide_t;
    typedef logic [COORD_W-1:0] coord_t;

    localparam wide_t      RANGE_X = wide_t'(H_RES - SPR_W);
    localparam wide_t      RANGE_Y = wide_t'(GROUND_Y - SPR_H);
    localparam wide_t      XS_W    = wide_t'(X_SPEED);
    localparam coord_t     XS_N    = coord_t'(X_SPEED);
    localparam coord_t     JV      = coord_t'(JUMP_V);
    localparam logic [2:0] G_LAST  = 3'(GRAVITY_DIV - 1);

    vga_game_pkg::motion_state_e state_q, state_d;
    coord_t     px_q, px_d;
    coord_t     py_q, py_d;
    coord_t     vy_q, vy_d;
    logic       dx_q, dx_d;
    logic       pend_q, pend_d;
    logic [2:0] gcnt_q, gcnt_d;

    wide_t      px_w, py_w, vy_w;
    wide_t      x_inc_w, rise_w, bot_w;
    logic       step, jump_now, tick;
    logic [2:0] gcnt_inc;
    coord_t     vy_dec;

    assign px_w     = {1'b0, px_q};
    assign py_w     = {1'b0, py_q};
    assign vy_w     = {1'b0, vy_q};
    assign x_inc_w  = px_w + XS_W;
    assign rise_w   = py_w + vy_w;
    assign bot_w    = wide_t'(GROUND_Y) - py_w;
    assign step     = bus.i_frame_end && !bus.i_pause;
    // a jump arriving on the frame-end cycle itself is honoured that frame
    assign jump_now = pend_q || bus.i_jump;
    assign tick     = (gcnt_q == G_LAST);
    assign gcnt_inc = tick ? 3'd0 : gcnt_q + 3'd1;
    assign vy_dec   = tick ? vy_q - coord_t'(1) : vy_q;

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        vy_d    = vy_q;
        dx_d    = dx_q;
        gcnt_d  = gcnt_q;
        pend_d  = step ? 1'b0 : (pend_q || bus.i_jump);

        if (step) begin
            if (dx_q) begin
                if (x_inc_w >= RANGE_X) begin
                    px_d = RANGE_X[COORD_W-1:0];
                    dx_d = 1'b0;
                end else begin
                    px_d = x_inc_w[COORD_W-1:0];
                end
            end else begin
                if (px_w <= XS_W) begin
                    px_d = '0;
                    dx_d = 1'b1;
                end else begin
                    px_d = px_q - XS_N;
                end
            end

            case (state_q)
                vga_game_pkg::ST_GROUND: begin
                    if (jump_now) begin
                        vy_d    = JV;
                        state_d = vga_game_pkg::ST_RISING;
                        gcnt_d  = '0;
                    end
                end
                vga_game_pkg::ST_RISING: begin
                    py_d = (rise_w >= RANGE_Y) ? RANGE_Y[COORD_W-1:0]
                                               : rise_w[COORD_W-1:0];
                    vy_d = vy_dec;
                    if (vy_dec == '0) begin
                        state_d = vga_game_pkg::ST_FALLING;
                        gcnt_d  = '0;
                    end else begin
                        gcnt_d  = gcnt_inc;
                    end
                end
                vga_game_pkg::ST_FALLING: begin
                    if (py_w <= vy_w) begin
                        py_d    = '0;
                        vy_d    = '0;
                        state_d = vga_game_pkg::ST_GROUND;
                        gcnt_d  = '0;
                    end else begin
                        py_d   = py_q - vy_q;
                        gcnt_d = gcnt_inc;
                        if (tick && (vy_q < JV)) begin
                            vy_d = vy_q + coord_t'(1);
                        end
                    end
                end
                default: begin
                    py_d    = '0;
                    vy_d    = '0;
                    state_d = vga_game_pkg::ST_GROUND;
                    gcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= vga_game_pkg::ST_GROUND;
            px_q    <= '0;
            py_q    <= '0;
            vy_q    <= '0;
            dx_q    <= 1'b1;
            pend_q  <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            vy_q    <= vy_d;
            dx_q    <= dx_d;
            pend_q  <= pend_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign bus.o_px    = px_q;
    assign bus.o_py    = py_q;
    assign bus.o_dx    = dx_q;
    assign bus.o_state = state_q;

    sprite_hit #(
        .COORD_W (COORD_W),
        .SPR_W   (SPR_W),
        .SPR_H   (SPR_H)
    ) u_hit (
        .i_h     (bus.i_h),
        .i_v     (bus.i_v),
        .i_x     (px_q),
        .i_y_bot (bot_w),
        .o_hit   (bus.o_in_sprite)
    );

endmodule
